// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and default sizing.
package fifo_wr_arbiter_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int DEF_N     = 8;
   localparam int DEF_REQS  = 4;
   localparam int DEF_BURST = 4;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO side bundle of the write arbiter.
interface fifo_wr_arbiter_if import fifo_wr_arbiter_pkg::*; #(
   parameter int N    = DEF_N,
   parameter int REQS = DEF_REQS
) ();
   logic [REQS-1:0]   req;
   logic [REQS*N-1:0] req_data;
   logic [REQS-1:0]   ack;
   logic [REQS-1:0]   grant;
   logic              fifo_full;
   logic              fifo_write;
   logic [N-1:0]      fifo_data;
   logic              busy;

   modport slave (
      input  req, req_data, fifo_full,
      output ack, grant, fifo_write, fifo_data, busy
   );

   modport master (
      output req, req_data, fifo_full,
      input  ack, grant, fifo_write, fifo_data, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular first-set search over a request vector, starting at a given index.
module fifo_wr_arbiter_rr_pick #(
   parameter int REQS = 4,
   parameter int IW   = $clog2(REQS)
) (
   input  logic [REQS-1:0] req,
   input  logic [IW-1:0]   start,
   output logic            found,
   output logic [IW-1:0]   winner
);
   int idx;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < REQS; k++) begin
         // wrap at REQS so non-power-of-two counts never probe a phantom index
         idx = int'(start) + k;
         if (idx >= REQS) idx = idx - REQS;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts of up to BURST beats into one shared FIFO.
module fifo_wr_arbiter import fifo_wr_arbiter_pkg::*; #(
   parameter int N     = DEF_N,
   parameter int REQS  = DEF_REQS,
   parameter int BURST = DEF_BURST
) (
   input  logic            clk,
   input  logic            rst_n,
   fifo_wr_arbiter_if.slave bus
);
   localparam int             IW   = $clog2(REQS);
   localparam int             CW   = $clog2(BURST) + 1;
   localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d, ptr_q, ptr_d, owner_nxt;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            idle_found, rel_found, beat, rel;
   logic [IW-1:0]   idle_win, rel_win;

   assign owner_nxt = (owner_q == IW'(REQS - 1)) ? '0 : owner_q + 1'b1;

   fifo_wr_arbiter_rr_pick #(.REQS(REQS), .IW(IW)) u_pick_idle (
      .req(bus.req), .start(ptr_q), .found(idle_found), .winner(idle_win)
   );

   // starting after the releasing owner makes it the lowest-priority candidate
   fifo_wr_arbiter_rr_pick #(.REQS(REQS), .IW(IW)) u_pick_rel (
      .req(bus.req), .start(owner_nxt), .found(rel_found), .winner(rel_win)
   );

   assign beat = (state_q == BUSY) && bus.req[owner_q] && !bus.fifo_full && rst_n;
   assign rel  = (state_q == BUSY) && (!bus.req[owner_q] || (beat && cnt_q == LAST));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (idle_found) begin
            state_d = BUSY;
            owner_d = idle_win;
            cnt_d   = '0;
         end
         BUSY: begin
            if (rel) begin
               ptr_d = owner_nxt;
               if (rel_found) begin
                  owner_d = rel_win;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.ack       = '0;
      bus.grant     = '0;
      bus.fifo_data = '0;
      if (state_q == BUSY) begin
         bus.grant[owner_q] = 1'b1;
         bus.fifo_data      = bus.req_data[owner_q*N +: N];
      end
      if (beat) bus.ack[owner_q] = 1'b1;
   end

   assign bus.fifo_write = beat;
   assign bus.busy       = (state_q == BUSY);
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 8: data width per requester and toward the FIFO.
REQ-002 Parameter REQS, default 4: number of requesters, range 2..8.
REQ-003 Parameter BURST, default 4: maximum beats per grant, range 1..16.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 req  input  REQS  per-requester write request; each bit stays high while that requester holds a beat.
REQ-008 req_data  input  REQS*N  flattened data; requester i occupies bits [i*N +: N].
REQ-009 ack  output  REQS  one-hot, combinational; pulses in each cycle a beat from requester i is written.
REQ-010 grant  output  REQS  one-hot registered owner; all zero when idle.
REQ-011 fifo_full  input  1  full flag from the shared FIFO.
REQ-012 fifo_write  output  1  combinational write strobe to the FIFO.
REQ-013 fifo_data  output  N  data of the current owner, muxed to the FIFO.
REQ-014 busy  output  1  high while in state BUSY.

Function
REQ-015 FSM shall have two states, IDLE and BUSY; registers are state, owner index, rr_ptr, and beat_cnt (width clog2(BURST)+1).
REQ-016 Beat condition: state==BUSY && req[owner] && !fifo_full && rst_n.
REQ-017 fifo_write and ack[owner] shall equal the beat condition; all other ack bits shall be 0.
REQ-018 fifo_data shall be the owner's slice whenever in BUSY, and 0 in IDLE.
REQ-019 In IDLE with any req bit set, the block shall pick the first set bit, searching circularly from rr_ptr.
REQ-020 It shall then load owner, set beat_cnt=0, and enter BUSY next cycle.
REQ-021 No write occurs in the arbitration cycle: first-beat latency is 1 clock from req.
REQ-022 In BUSY, each beat shall increment beat_cnt.
REQ-023 In BUSY with fifo_full high and req[owner] high, the block shall stall: it holds owner and beat_cnt and writes nothing.
REQ-024 Release shall occur on either condition: (a) a beat with beat_cnt==BURST-1; (b) req[owner] low.
REQ-025 On release, rr_ptr shall be set to (owner+1) mod REQS.
REQ-026 On release, the next owner shall be picked in the same cycle, searching circularly from (owner+1).
REQ-027 In that search, the releasing owner has lowest priority, but its req bit is still eligible.
REQ-028 If the search finds a requester, BUSY continues with the new owner and beat_cnt=0; otherwise the next state is IDLE.
REQ-029 grant shall be the one-hot decode of owner in BUSY, and 0 in IDLE.
REQ-030 The block shall never assert fifo_write while fifo_full is high, so no data is dropped by the FIFO.
REQ-031 A requester whose req drops mid-burst forfeits the rest of its burst, and no beat is counted that cycle.
REQ-032 REQS not a power of two: all modulo arithmetic on owner and rr_ptr wraps at REQS, not at 2^width.

Reset
REQ-033 rst_n low at a clock edge shall force: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
REQ-034 After that edge, grant=0 and busy=0.
REQ-035 While rst_n is low, fifo_write=0 and ack=0, including mid-burst; the in-flight beat is not written.
REQ-036 After reset, requester 0 shall have highest priority for the first arbitration.

Structure
REQ-037 A shared header/package shall hold the state encodings (IDLE=0, BUSY=1) and the default REQS, BURST and N.
REQ-038 One combinational sub-module, rr_pick, shall be used: inputs req vector and start index; outputs found flag and winner index.
REQ-039 rr_pick shall be instantiated once for the IDLE search and once for the release search.

Verification
REQ-040 Single requester: req=4'b0001 held, BURST=4, fifo not full.
  - Response: grant=0001 from cycle 1; fifo_write on cycles 1-4; re-grant to 0 with zero gap; writes continue every cycle.
REQ-041 All four requesters held, BURST=2.
  - Response: grant sequence 0,1,2,3,0; exactly 2 beats each; ack matches grant.
REQ-042 fifo_full forced high for 3 cycles mid-burst of requester 2 after 1 beat.
  - Response: no fifo_write and no ack for 3 cycles; owner stays 2; then 3 more beats; total 4.
REQ-043 Requester 1 drops req after 1 beat while req[3] is high.
  - Response: release that cycle; grant=1000 next cycle; rr_ptr=2.
REQ-044 rst_n low for 1 cycle during a beat of requester 3.
  - Response: fifo_write=0 that cycle; next cycle IDLE with grant=0; next arbitration with req=4'b1001 grants requester 0.
REQ-045 REQS=3, requesters 0 and 2 held, BURST=1.
  - Response: grants alternate 0,2,0,2; owner never reaches index 3.
